adder_serial: RTL
=================

# adder_serial

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operand pair CHUNK bits per clock, LSB chunk first, using a start/busy/done handshake. It replaces the fixed 2-bit combinational adder wherever wide operands must be added with a small carry chain and a registered result. Outputs are carry-out and signed-overflow flags. Results are held until the next accepted operation.

## Interface

- WIDTH, 8: operand and result width. Must be ≥1.
- CHUNK, 2: bits added per cycle. WIDTH must be an integer multiple of CHUNK. NCH = WIDTH/CHUNK.

- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; captured when start is accepted.
- b  in  WIDTH  operand B; captured when start is accepted.
- sub  in  1  0 = add, 1 = subtract (a − b); captured with operands.
- cin  in  1  carry-in for add; ignored when sub=1; captured with operands.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when y/cout/ovf are updated.
- y  out  WIDTH  result, registered.
- cout  out  1  carry out of MSB. For sub, 1 = no borrow (a ≥ b unsigned).
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation

- States: IDLE, RUN.
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, y=0, cout=0, ovf=0. The chunk counter, operand latches and internal partial result are cleared.
- IDLE with start=1: latch a, b, sub, cin.
  - Effective B = sub ? ~b : b.
  - Carry register = sub ? 1 : cin.
  - Chunk index k = 0. Go to RUN. busy=1.
- RUN, each edge:
  - Add chunk k of A, chunk k of effective B and the carry register.
  - Store the CHUNK-bit sum into bits [k*CHUNK +: CHUNK] of the internal partial result.
  - Update the carry register. k increments.
- On the edge that processes k = NCH−1:
  - y ← full partial result including the final chunk.
  - cout ← final carry.
  - ovf ← carry into bit WIDTH−1 XOR final carry.
  - done=1, busy=0, state=IDLE.
- done is high exactly one cycle. It deasserts on the next edge unless that edge completes another operation, which is impossible because NCH ≥ 1 requires at least one RUN edge.
- y, cout and ovf change only on the completing edge and are held otherwise, including throughout a following operation until it completes.
- start while in RUN is ignored. Operand inputs are don't-care outside the accepting edge.
- start during the cycle done is high is accepted, because state is already IDLE. This allows back-to-back operation.
- Degenerate NCH=1: one RUN edge, which is fully combinational add, registered.
- Arithmetic is modulo 2^WIDTH. There is no saturation.

## Timing

- The start-accept edge is E0. Chunks are processed on edges E1..E_NCH.
- busy is high from after E0 until after E_NCH.
- done, y, cout and ovf are valid after E_NCH.
- Latency is NCH+1 edges from the start-sample edge to the done pulse.
- Throughput: one operation per NCH+1 cycles with start held high continuously.
- Reset mid-RUN aborts immediately. No done is produced, and y/cout/ovf read 0.
- After reset is released, the first edge with start=1 is accepted.
- The critical path is a CHUNK-bit carry chain plus the carry register.

## Test plan

- WIDTH=8, CHUNK=2: a=0x0F, b=0x01, sub=0, cin=0, pulse start → done exactly 4 edges after the accept edge (busy high during those 4 cycles), with y=0x10, cout=0, ovf=0. Check y holds until the next done.
- Carry/overflow add:
  - a=0xFF, b=0x01 → y=0x00, cout=1, ovf=0.
  - a=0x7F, b=0x01 → y=0x80, cout=0, ovf=1.
  - a=0x00, b=0x00, cin=1 → y=0x01.
- Subtract:
  - a=0x05, b=0x07, sub=1, cin=1 (must be ignored) → y=0xFE, cout=0, ovf=0.
  - a=0x80, b=0x01, sub=1 → y=0x7F, cout=1, ovf=1.
- Handshake:
  - Pulse start again during RUN with different operands → ignored; result reflects the first operands.
  - Hold start high continuously → done pulses every 5 cycles with successive results.
- Reset: assert rst_n=0 asynchronously mid-cycle during the 2nd RUN cycle → busy, done, y, cout and ovf read 0 immediately. No done follows. A fresh start after release completes normally.
- Parameter sweep:
  - WIDTH=2, CHUNK=1: all 16 (a,b) combinations with sub=0 and cin=0 → y=(a+b) mod 4, cout=(a+b)>3, latency 3 edges.
  - WIDTH=8, CHUNK=8: 0x7F+0x01 → y=0x80, ovf=1, done after 1 RUN edge.

Source files
------------

// File: rtl/adder_serial.sv
// Multi-cycle adder/subtractor: adds a WIDTH-bit operand pair CHUNK bits per clock,
// LSB chunk first, with a start/busy/done handshake and registered result/flags.
module adder_serial #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NCH = WIDTH / CHUNK;
    localparam int unsigned KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [KW-1:0] KLast = KW'(NCH - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;      // effective B (already inverted for subtract)
    logic             carry_q, carry_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;

    // Next-state logic: operand capture in idle, one chunk of ripple per run cycle.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        k_d     = k_q;
        part_d  = part_q;
        y_d     = y_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        a_chunk   = a_q[k_q*CHUNK +: CHUNK];
        b_chunk   = b_q[k_q*CHUNK +: CHUNK];
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub | cin;   // subtract forces +1 of two's complement
                    k_d     = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                part_d[k_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
                carry_d = chunk_sum[CHUNK];
                k_d     = k_q + 1'b1;
                if (k_q == KLast) begin
                    y_d    = part_d;
                    cout_d = chunk_sum[CHUNK];
                    // Carry into the MSB recovered from its sum bit: a ^ b ^ s.
                    ovf_d  = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ chunk_sum[CHUNK-1] ^ chunk_sum[CHUNK];
                    done_d = 1'b1;
                    k_d    = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            part_q  <= '0;
            y_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            part_q  <= part_d;
            y_q     <= y_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        busy = (state_q == StRun);
        done = done_q;
        y    = y_q;
        cout = cout_q;
        ovf  = ovf_q;
    end

endmodule
